// File: rtl/status_event_monitor.sv
// Status-change event monitor: queues {prev, curr} pairs whenever the status byte changes.
// Optional STATUS_MON_TIMESTAMP_EN adds a 16-bit cycle timestamp (evt_ts) per event.
module status_event_monitor #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   status_in,
    output logic                         evt_valid,
    input  logic                         evt_ready,
    output logic [7:0]                   evt_prev,
    output logic [7:0]                   evt_curr,
    output logic [$clog2(DEPTH+1)-1:0]   pending,
    output logic                         overflow,
    input  logic                         clr_overflow,
    output logic                         game_over,
    output logic                         error
`ifdef STATUS_MON_TIMESTAMP_EN
    ,
    output logic [15:0]                  evt_ts
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned ST_W  = 8;
    localparam int unsigned TS_W  = 16;

`ifdef STATUS_MON_TIMESTAMP_EN
    typedef struct packed {
        logic [TS_W-1:0] ts;
        logic [ST_W-1:0] prev;
        logic [ST_W-1:0] curr;
    } evt_t;
`else
    typedef struct packed {
        logic [ST_W-1:0] prev;
        logic [ST_W-1:0] curr;
    } evt_t;
`endif

    logic [ST_W-1:0]  last_q, last_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] pending_q, pending_d;
    logic             overflow_q, overflow_d;
    evt_t             mem_q [DEPTH];
    evt_t             entry;
    evt_t             head;
    logic             change, full, push, pop;

`ifdef STATUS_MON_TIMESTAMP_EN
    logic [TS_W-1:0]  ts_q, ts_d;
`endif

    // Push/pop decisions; a full FIFO still accepts a push when it pops in the same cycle
    always_comb begin
        change = (status_in != last_q);
        full   = (pending_q == CNT_W'(DEPTH));
        pop    = (pending_q != '0) && evt_ready;
        push   = change && (!full || pop);

        last_d   = status_in;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        pending_d = pending_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   pending_d = pending_q + CNT_W'(1);
            2'b01:   pending_d = pending_q - CNT_W'(1);
            default: pending_d = pending_q;
        endcase

        // Set beats clear
        overflow_d = overflow_q;
        if (change && full && !pop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_comb begin
        entry      = '0;
        entry.prev = last_q;
        entry.curr = status_in;
`ifdef STATUS_MON_TIMESTAMP_EN
        entry.ts   = ts_q;
`endif
    end

`ifdef STATUS_MON_TIMESTAMP_EN
    always_comb begin
        ts_d = ts_q + TS_W'(1);
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
`ifdef STATUS_MON_TIMESTAMP_EN
            ts_q       <= '0;
`endif
        end else begin
            last_q     <= last_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
`ifdef STATUS_MON_TIMESTAMP_EN
            ts_q       <= ts_d;
`endif
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= entry;
        end
    end

    always_comb begin
        head = '0;
        if (pending_q != '0) begin
            head = mem_q[rd_ptr_q];
        end
    end

    assign evt_valid = (pending_q != '0);
    assign evt_prev  = head.prev;
    assign evt_curr  = head.curr;
    assign pending   = pending_q;
    assign overflow  = overflow_q;
    assign game_over = last_q[0];
    assign error     = last_q[1];
`ifdef STATUS_MON_TIMESTAMP_EN
    assign evt_ts    = head.ts;
`endif

endmodule
